mips_mc: RTL

Parametrised multicycle MIPS-subset core and the successor to the fixed 8-bit multicycle processor. The datapath width and register count are parameters. Instructions are fetched in `32/WIDTH` beats. Every memory access waits on a ready handshake. The core adds `bne` and a sticky halt on illegal opcodes. It sits between the synthesised memory model and the top-level testbench, and exposes the same memory-facing signals plus `memready` and `halted`.

---
 rtl/mips_mc_if.sv | 22 ++
 rtl/mips_mc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_if.sv
// Memory-facing bus of the multicycle core: request/address/data out, read data and
// ready handshake back.
interface mips_mc_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] memdata;
    logic             memready;
    logic             memread;
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;

    modport master (
        input  memdata, memready,
        output memread, memwrite, adr, writedata
    );

    modport slave (
        output memdata, memready,
        input  memread, memwrite, adr, writedata
    );
endinterface

// File: rtl/mips_mc.sv
// Parametrised multicycle MIPS-subset core: beat-wise instruction fetch, ready-gated memory
// accesses, beq/bne, and a sticky halt on illegal opcodes.
module mips_mc #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned REGBITS = 3
) (
    input  logic      clk,
    input  logic      reset,
    mips_mc_if.master bus,
    output logic      halted
);
    localparam int unsigned BEATS = 32 / WIDTH;
    localparam int unsigned Shamt = $clog2(BEATS);
    localparam int unsigned BeatW = (Shamt > 0) ? Shamt : 1;
    localparam int unsigned NRegs = 1 << REGBITS;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLb    = 6'b100000;
    localparam logic [5:0] OpSb    = 6'b101000;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StLbRd, StLbWr, StSbWr,
        StRtypeEx, StRtypeWr, StBrEx, StJEx, StAddiWr, StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;

    logic [WIDTH-1:0] rf_q [NRegs];
    logic             rf_we;
    logic [REGBITS-1:0] rf_wa;
    logic [WIDTH-1:0] rf_wd;

    logic [5:0]         op;
    logic [4:0]         rs5, rt5, rd5;
    logic [REGBITS-1:0] rs_a, rt_a, rd_a;
    logic [WIDTH-1:0]   rs_val, rt_val;
    logic [31:0]        imm32, jt32;
    logic [WIDTH-1:0]   imm, boff, jtarget, diff, alu_res;
    logic [4:0]         slot_lo;
    logic               last_beat;
    logic               memread, memwrite;
    logic [WIDTH-1:0]   adr, writedata;

    assign op     = instr_q[31:26];
    assign rs5    = instr_q[25:21];
    assign rt5    = instr_q[20:16];
    assign rd5    = instr_q[15:11];
    assign rs_a   = rs5[REGBITS-1:0];
    assign rt_a   = rt5[REGBITS-1:0];
    assign rd_a   = rd5[REGBITS-1:0];
    assign rs_val = (rs_a == '0) ? '0 : rf_q[rs_a];
    assign rt_val = (rt_a == '0) ? '0 : rf_q[rt_a];

    assign imm32   = {{16{instr_q[15]}}, instr_q[15:0]};
    assign imm     = imm32[WIDTH-1:0];
    assign boff    = imm << Shamt;
    assign jt32    = {6'b0, instr_q[25:0]} << Shamt;
    assign jtarget = jt32[WIDTH-1:0];
    assign diff    = a_q - b_q;

    // Beat 0 lands in the most-significant slot of the instruction word.
    assign slot_lo   = 5'((BEATS - 1 - 32'(beat_q)) * WIDTH);
    assign last_beat = (32'(beat_q) == BEATS - 1);

    logic unused_bits;
    assign unused_bits = ^{instr_q[10:6], rs5, rt5, rd5, imm32, jt32};

    always_comb begin
        unique case (instr_q[5:0])
            FnAdd:   alu_res = a_q + b_q;
            FnSub:   alu_res = diff;
            FnAnd:   alu_res = a_q & b_q;
            FnOr:    alu_res = a_q | b_q;
            FnSlt:   alu_res = WIDTH'($signed(a_q) < $signed(b_q));
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_wa     = rt_a;
        rf_wd     = mdr_q;
        memread   = 1'b0;
        memwrite  = 1'b0;
        adr       = '0;
        writedata = '0;
        halted    = 1'b0;
        case (state_q)
            StFetch: begin
                memread = 1'b1;
                adr     = pc_q;
                if (bus.memready) begin
                    instr_d[slot_lo +: WIDTH] = bus.memdata;
                    pc_d = pc_q + WIDTH'(1);
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = StDecode;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StDecode: begin
                a_d   = rs_val;
                b_d   = rt_val;
                alu_d = pc_q + boff;
                case (op)
                    OpLb, OpSb, OpAddi: state_d = StMemAdr;
                    OpRtype:            state_d = StRtypeEx;
                    OpBeq, OpBne:       state_d = StBrEx;
                    OpJ:                state_d = StJEx;
                    default:            state_d = StHalt;
                endcase
            end
            StMemAdr: begin
                alu_d = a_q + imm;
                case (op)
                    OpLb:    state_d = StLbRd;
                    OpSb:    state_d = StSbWr;
                    default: state_d = StAddiWr;
                endcase
            end
            StLbRd: begin
                memread = 1'b1;
                adr     = alu_q;
                if (bus.memready) begin
                    mdr_d   = bus.memdata;
                    state_d = StLbWr;
                end
            end
            StLbWr: begin
                rf_we   = 1'b1;
                state_d = StFetch;
            end
            StSbWr: begin
                memwrite  = 1'b1;
                adr       = alu_q;
                writedata = b_q;
                if (bus.memready) state_d = StFetch;
            end
            StAddiWr: begin
                rf_we   = 1'b1;
                rf_wd   = alu_q;
                state_d = StFetch;
            end
            StRtypeEx: begin
                alu_d   = alu_res;
                state_d = StRtypeWr;
            end
            StRtypeWr: begin
                rf_we   = 1'b1;
                rf_wa   = rd_a;
                rf_wd   = alu_q;
                state_d = StFetch;
            end
            StBrEx: begin
                // beq takes on zero difference, bne on nonzero.
                if ((op == OpBeq) == (diff == '0)) pc_d = alu_q;
                state_d = StFetch;
            end
            StJEx: begin
                pc_d    = jtarget;
                state_d = StFetch;
            end
            StHalt:  halted = 1'b1;
            default: state_d = StFetch;
        endcase
    end

    assign bus.memread   = memread;
    assign bus.memwrite  = memwrite;
    assign bus.adr       = adr;
    assign bus.writedata = writedata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            beat_q  <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // Write enable comes from the state, so an asynchronous reset also cancels any pending write.
    always_ff @(posedge clk) begin
        if (rf_we && rf_wa != '0) rf_q[rf_wa] <= rf_wd;
    end
endmodule
